// File: rtl/key_judge.sv
// Debounces seven piano keys, encodes a single held key and judges each new press against target_key.
// Optional hit/miss statistics counters are built when KEY_JUDGE_STATS_EN is defined.
module key_judge #(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int CNT_W           = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [6:0]       keys_raw,
    input  logic [3:0]       target_key,
    input  logic             armed,
    output logic             correct_key_press,
    output logic             wrong_key_press,
    output logic [3:0]       pressed_key,
    output logic             key_valid,
    output logic [CNT_W-1:0] hit_count,
    output logic [CNT_W-1:0] miss_count
);
    localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [DB_W-1:0] DB_MAX = DB_W'(DEBOUNCE_CYCLES);

    typedef enum logic [1:0] {IDLE, HELD, BLOCKED} state_t;

    logic [6:0]      sync_p0, sync_p1, stable;
    logic [DB_W-1:0] db_cnt [7];
    logic            any_down;
    logic            stable_onehot;
    logic [3:0]      stable_idx;
    state_t          state;
    logic            press_evt;
    logic            press_hit;

    function automatic logic [3:0] key_index(input logic [6:0] v);
        logic [3:0] idx;
        idx = 4'hF;
        for (int i = 0; i < 7; i++) begin
            if (v[i]) idx = 4'(i);
        end
        return idx;
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (c == {CNT_W{1'b1}}) ? c : c + 1'b1;
    endfunction

    // Stage: two-flop synchronizer, then per-key debounce
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_p0 <= '0;
            sync_p1 <= '0;
            stable  <= '0;
            for (int i = 0; i < 7; i++) db_cnt[i] <= '0;
        end else begin
            sync_p0 <= keys_raw;
            sync_p1 <= sync_p0;
            for (int i = 0; i < 7; i++) begin
                if (sync_p1[i] == stable[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] == DB_MAX) begin
                    stable[i] <= sync_p1[i];
                    db_cnt[i] <= '0;
                end else begin
                    db_cnt[i] <= db_cnt[i] + 1'b1;
                end
            end
        end
    end

    assign stable_onehot = (stable != 7'd0) && ((stable & (stable - 7'd1)) == 7'd0);
    assign stable_idx    = stable_onehot ? key_index(stable) : 4'hF;

    // Stage: registered encoder
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            key_valid   <= 1'b0;
            pressed_key <= 4'hF;
            any_down    <= 1'b0;
        end else begin
            key_valid   <= stable_onehot;
            pressed_key <= stable_idx;
            any_down    <= (stable != 7'd0);
        end
    end

    // Stage: press FSM with registered judgment pulses
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state             <= IDLE;
            correct_key_press <= 1'b0;
            wrong_key_press   <= 1'b0;
        end else begin
            correct_key_press <= 1'b0;
            wrong_key_press   <= 1'b0;
            case (state)
                IDLE: begin
                    if (key_valid) begin
                        state             <= HELD;
                        correct_key_press <= armed && (pressed_key == target_key);
                        wrong_key_press   <= armed && (pressed_key != target_key);
                    end else if (any_down) begin
                        state <= BLOCKED;
                    end
                end
                HELD:    if (!any_down) state <= IDLE;
                BLOCKED: if (!any_down) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign press_evt = (state == IDLE) && key_valid && armed;
    assign press_hit = pressed_key == target_key;

`ifdef KEY_JUDGE_STATS_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hit_count  <= '0;
            miss_count <= '0;
        end else if (press_evt) begin
            if (press_hit) hit_count  <= sat_inc(hit_count);
            else           miss_count <= sat_inc(miss_count);
        end
    end
`else
    logic unused_stats;
    assign unused_stats = press_evt ^ press_hit ^ (^sat_inc('0));
    assign hit_count    = '0;
    assign miss_count   = '0;
`endif

endmodule

// File: tb/tb_key_judge.sv
// Directed bench for key_judge with DEBOUNCE_CYCLES=4: press judgment, bounce, chords, saturation, reset.
module tb_key_judge;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [6:0] keys_raw = '0;
    logic [3:0] target_key = '0;
    logic       armed = 1'b0;
    logic       correct_key_press, wrong_key_press, key_valid;
    logic [3:0] pressed_key;
    logic [7:0] hit_count, miss_count;

`ifdef KEY_JUDGE_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    key_judge #(.DEBOUNCE_CYCLES(4), .CNT_W(8)) dut (
        .clk(clk), .rst(rst), .keys_raw(keys_raw), .target_key(target_key), .armed(armed),
        .correct_key_press(correct_key_press), .wrong_key_press(wrong_key_press),
        .pressed_key(pressed_key), .key_valid(key_valid),
        .hit_count(hit_count), .miss_count(miss_count)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    int n_corr = 0, n_wrong = 0, corr_cyc = -1, kv_seen = 0;
    int passed = 0, total = 0;
    int hit_m = 0, miss_m = 0;
    int press_cyc;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (correct_key_press) begin n_corr = n_corr + 1; corr_cyc = cyc; end
        if (wrong_key_press) n_wrong = n_wrong + 1;
        if (key_valid) kv_seen = 1;
    end

    task automatic check(input string tag, input int got, input int exp);
        total = total + 1;
        if (got == exp) passed = passed + 1;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic clr_mon();
        n_corr = 0; n_wrong = 0; corr_cyc = -1; kv_seen = 0;
    endtask

    task automatic check_counts(input string tag);
        check({tag, "_hit"}, int'(hit_count), STATS ? hit_m : 0);
        check({tag, "_miss"}, int'(miss_count), STATS ? miss_m : 0);
    endtask

    task automatic press(input logic [6:0] k);
        keys_raw = k;
        press_cyc = cyc + 1;
    endtask

    initial begin
        step(3);
        check("rst_kv", int'(key_valid), 0);
        check("rst_pk", int'(pressed_key), 15);
        check("rst_corr", int'(correct_key_press), 0);
        check("rst_wrong", int'(wrong_key_press), 0);
        check_counts("rst");
        rst = 1'b0;
        step(2);

        // Armed match on key 4
        armed = 1'b1; target_key = 4'd4; clr_mon();
        press(7'b001_0000);
        step(12);
        check("match_pk", int'(pressed_key), 4);
        check("match_kv", int'(key_valid), 1);
        step(8);
        hit_m = hit_m + 1;
        check("match_corr_n", n_corr, 1);
        check("match_wrong_n", n_wrong, 0);
        check("match_latency", corr_cyc - press_cyc, 8);
        check_counts("match");
        keys_raw = '0; step(12);
        check("release_pk", int'(pressed_key), 15);

        // Armed mismatch: key 2 vs target 0
        target_key = 4'd0; clr_mon();
        press(7'b000_0100); step(12);
        miss_m = miss_m + 1;
        check("mis_wrong_n", n_wrong, 1);
        check("mis_corr_n", n_corr, 0);
        check_counts("mis");
        keys_raw = '0; step(12);

        // Disarmed press of key 0
        armed = 1'b0; clr_mon();
        press(7'b000_0001); step(12);
        check("dis_pk", int'(pressed_key), 0);
        check("dis_pulses", n_corr + n_wrong, 0);
        check_counts("dis");
        keys_raw = '0; step(12);

        // Bounce on key 1 never settles
        armed = 1'b1; target_key = 4'd1; clr_mon();
        for (int r = 0; r < 5; r++) begin
            keys_raw = 7'b000_0010; step(3);
            keys_raw = 7'b000_0000; step(2);
        end
        step(10);
        check("bounce_kv", kv_seen, 0);
        check("bounce_pulses", n_corr + n_wrong, 0);
        press(7'b000_0010); step(10);
        keys_raw = '0; step(12);
        hit_m = hit_m + 1;
        check("bounce_hold_corr", n_corr, 1);
        check("bounce_hold_wrong", n_wrong, 0);
        check_counts("bounce");

        // Chord goes to BLOCKED
        clr_mon();
        press(7'b000_1010); step(12);
        check("chord_pk", int'(pressed_key), 15);
        check("chord_kv", kv_seen, 0);
        check("chord_pulses", n_corr + n_wrong, 0);
        keys_raw = '0; step(12);

        // Hold key 3, then add key 5
        target_key = 4'd3; clr_mon();
        press(7'b000_1000); step(12);
        keys_raw = 7'b010_1000; step(12);
        check("add_pk", int'(pressed_key), 15);
        keys_raw = '0; step(12);
        hit_m = hit_m + 1;
        check("add_corr_n", n_corr, 1);
        check("add_wrong_n", n_wrong, 0);
        check_counts("add");

        // Saturation over 260 presses
        target_key = 4'd5;
        for (int r = 0; r < 260; r++) begin
            clr_mon();
            press(7'b010_0000); step(12);
            keys_raw = '0; step(12);
            if (hit_m < 255) hit_m = hit_m + 1;
        end
        check("sat_last_corr", n_corr, 1);
        check_counts("sat");

        // Arming while held gives no event
        armed = 1'b0; target_key = 4'd2; clr_mon();
        press(7'b000_0100); step(12);
        armed = 1'b1; step(10);
        check("rearm_held", n_corr + n_wrong, 0);
        keys_raw = '0; step(12);
        press(7'b000_0100); step(12);
        check("rearm_repress", n_corr, 1);
        keys_raw = '0; step(12);

        // Reset during HELD, key 6 kept down through reset
        target_key = 4'd6; clr_mon();
        press(7'b100_0000); step(12);
        check("pre_rst_pk", int'(pressed_key), 6);
        @(posedge clk); #2;
        rst = 1'b1; #1;
        check("mid_rst_kv", int'(key_valid), 0);
        check("mid_rst_pk", int'(pressed_key), 15);
        hit_m = 0; miss_m = 0;
        check_counts("mid_rst");
        step(2);
        rst = 1'b0; clr_mon();
        press_cyc = cyc + 1;
        step(14);
        hit_m = 1;
        check("post_rst_corr", n_corr, 1);
        check("post_rst_latency", corr_cyc - press_cyc, 8);
        check_counts("post_rst");

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
